// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_XNOR = 4'd7;
    localparam logic [3:0] OP_NOT  = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_SRA  = 4'd11;
    localparam logic [3:0] OP_ROL  = 4'd12;
    localparam logic [3:0] OP_CMP  = 4'd13;
    localparam logic [3:0] OP_MUL  = 4'd14;
    localparam logic [3:0] OP_DIV  = 4'd15;

    localparam int unsigned FLAG_ZERO  = 0;
    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned FLAG_OVF   = 2;
    localparam int unsigned FLAG_DIV0  = 3;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } alu_state_e;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide, one bit per cycle.
module alu_seq_muldiv #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);
    localparam int unsigned CNT_W   = SHAMT_W + 1;

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opd_q;
    logic             mode_q, run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   mul_sum, div_shift;

    // hi is the product high word / partial remainder; lo is the multiplier / dividend-quotient.
    // A zero divisor naturally yields an all-ones quotient and remainder equal to the dividend.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        done      = run_q && (cnt_q == CNT_W'(WIDTH - 1));
        hi_d      = hi_q;
        lo_d      = lo_q;
        run_d     = run_q;
        cnt_d     = cnt_q;
        if (start) begin
            hi_d  = '0;
            lo_d  = a;
            run_d = 1'b1;
            cnt_d = '0;
        end else if (run_q) begin
            if (!mode_q) begin
                {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
            end else if (div_shift >= {1'b0, opd_q}) begin
                hi_d = div_shift[WIDTH-1:0] - opd_q;
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = div_shift[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (done) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opd_q  <= '0;
            mode_q <= 1'b0;
            run_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            run_q <= run_d;
            cnt_q <= cnt_d;
            if (start) begin
                opd_q  <= b;
                mode_q <= mode;
            end
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/alu_seq_param.sv
// Registered WIDTH-bit ALU with valid/ready handshakes, 16 opcodes and iterative MUL/DIV.
module alu_seq_param #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags,
    output logic             busy
);
    import alu_pkg::*;

    localparam int unsigned SHAMT_W = $clog2(WIDTH);
    localparam int unsigned RSH_W   = SHAMT_W + 1;

    alu_state_e       state_q, state_d;
    logic             accept, is_md, md_start, md_done, show_md, md_zero;
    logic [WIDTH-1:0] md_hi, md_lo;
    logic [WIDTH-1:0] x_q, y_q;
    logic [3:0]       flags_q;
    logic             md_sel_q, md_div_q, div0_q;

    logic [WIDTH:0]   sum, dif;
    logic [SHAMT_W-1:0] shamt;
    logic [RSH_W-1:0] rsh;
    logic [WIDTH-1:0] res_x, res_y;
    logic             res_carry, res_ovf;
    logic [3:0]       res_flags;

    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        dif       = {1'b0, a} - {1'b0, b};
        shamt     = b[SHAMT_W-1:0];
        rsh       = RSH_W'(WIDTH) - {1'b0, shamt};
        res_x     = '0;
        res_y     = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        case (opcode)
            OP_ADD: begin
                res_x     = sum[WIDTH-1:0];
                res_y     = WIDTH'(sum[WIDTH]);
                res_carry = sum[WIDTH];
                res_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res_x     = dif[WIDTH-1:0];
                res_y     = WIDTH'(dif[WIDTH]);
                res_carry = dif[WIDTH];
                res_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  res_x = a & b;
            OP_OR:   res_x = a | b;
            OP_XOR:  res_x = a ^ b;
            OP_NAND: res_x = ~(a & b);
            OP_NOR:  res_x = ~(a | b);
            OP_XNOR: res_x = ~(a ^ b);
            OP_NOT:  res_x = ~a;
            OP_SHL:  res_x = a << shamt;
            OP_SHR:  res_x = a >> shamt;
            OP_SRA:  res_x = $unsigned($signed(a) >>> shamt);
            OP_ROL:  res_x = (a << shamt) | (a >> rsh);
            OP_CMP:  res_x = {{(WIDTH - 3){1'b0}}, a > b, a == b, a < b};
            default: res_x = '0;
        endcase
        res_flags             = '0;
        res_flags[FLAG_ZERO]  = (res_x == '0);
        res_flags[FLAG_CARRY] = res_carry;
        res_flags[FLAG_OVF]   = res_ovf;
    end

    assign is_md    = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign accept   = (state_q == StIdle) && in_valid;
    assign md_start = accept && is_md;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = (opcode == OP_MUL) ? StMul :
                              (opcode == OP_DIV) ? StDiv : StDone;
                end
            end
            StMul, StDiv: begin
                busy = 1'b1;
                if (md_done) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            flags_q  <= '0;
            md_sel_q <= 1'b0;
            md_div_q <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                md_sel_q <= is_md;
                md_div_q <= (opcode == OP_DIV);
                div0_q   <= (opcode == OP_DIV) && (b == '0);
                x_q      <= is_md ? '0 : res_x;
                y_q      <= is_md ? '0 : res_y;
                flags_q  <= is_md ? '0 : res_flags;
            end
        end
    end

    alu_seq_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk  (clk),
        .rst  (rst),
        .start(md_start),
        .mode (opcode == OP_DIV),
        .a    (a),
        .b    (b),
        .done (md_done),
        .hi   (md_hi),
        .lo   (md_lo)
    );

    // MUL/DIV results are read straight from the datapath registers, which hold once done.
    always_comb begin
        show_md = (state_q == StDone) && md_sel_q;
        md_zero = (md_lo == '0) && (md_div_q || (md_hi == '0));
        x       = show_md ? md_lo : x_q;
        y       = show_md ? md_hi : y_q;
        flags   = show_md ? {div0_q, 2'b00, md_zero} : flags_q;
    end

endmodule
